// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: feeder and transmitter state encodings, default byte width
package uart_pkg;

    localparam int N_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        FEED_IDLE      = 3'b001,
        FEED_START     = 3'b010,
        FEED_WAIT_DONE = 3'b100
    } feed_state_t;

    typedef enum logic [3:0] {
        TX_IDLE  = 4'b0001,
        TX_START = 4'b0010,
        TX_DATA  = 4'b0100,
        TX_STOP  = 4'b1000
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - small synchronous FIFO with registered full/empty/count and overflow pulse
module sync_fifo #(
    parameter int N_BITS    = 8,
    parameter int ADDR_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [N_BITS-1:0]    wdata,
    output logic [N_BITS-1:0]    rdata,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [N_BITS-1:0]    mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   count_next;
    logic                 wr_en;
    logic                 rd_en;

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign rdata = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({wr_en, rd_en})
            2'b10:   count_next = count + (ADDR_BITS+1)'(1);
            2'b01:   count_next = count - (ADDR_BITS+1)'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_BITS'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ADDR_BITS'(1);
            end
            count    <= count_next;
            full     <= (count_next == (ADDR_BITS+1)'(DEPTH));
            empty    <= (count_next == '0);
            overflow <= push & full;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - buffers producer bytes and launches them one at a time into the UART transmitter
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int N_BITS    = N_BITS_DEFAULT,
    parameter int ADDR_BITS = 2
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_wr,
    input  logic [N_BITS-1:0]    i_wdata,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [ADDR_BITS:0]   o_count,
    output logic                 o_overflow,
    output logic                 o_tx_start,
    output logic [N_BITS-1:0]    o_tx_data,
    input  logic                 i_tx_done_tick,
    output logic                 o_busy
);

    feed_state_t       state;
    feed_state_t       state_next;
    logic              pop;
    logic [N_BITS-1:0] rdata;

    sync_fifo #(
        .N_BITS    (N_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_fifo (
        .clk      (i_clock),
        .rst_n    (i_reset_n),
        .push     (i_wr),
        .pop      (pop),
        .wdata    (i_wdata),
        .rdata    (rdata),
        .full     (o_full),
        .empty    (o_empty),
        .count    (o_count),
        .overflow (o_overflow)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= FEED_IDLE;
            o_tx_data <= '0;
        end else begin
            state <= state_next;
            if (pop) begin
                o_tx_data <= rdata;
            end
        end
    end

    // Done ticks only matter in WAIT_DONE; IDLE and START ignore them.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            FEED_IDLE: begin
                if (!o_empty) begin
                    pop        = 1'b1;
                    state_next = FEED_START;
                end
            end
            FEED_START: begin
                state_next = FEED_WAIT_DONE;
            end
            FEED_WAIT_DONE: begin
                if (i_tx_done_tick) begin
                    state_next = FEED_IDLE;
                end
            end
            default: begin
                state_next = FEED_IDLE;
            end
        endcase
    end

    // START lasts exactly one cycle, so its state bit is the start pulse.
    assign o_tx_start = (state == FEED_START);
    assign o_busy     = (state != FEED_IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed bench for uart_tx_feeder with a bit-level transmitter model
module tb_uart_tx_feeder;

    logic       clk;
    logic       rst_n;
    logic       wr;
    logic [7:0] wdata;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       busy;

    logic       use_model   = 1'b0;
    logic       done_manual = 1'b0;
    logic       done_model  = 1'b0;
    logic       m_busy      = 1'b0;
    logic [9:0] m_sh        = '0;
    logic [9:0] rx          = '0;
    logic [3:0] m_bit       = '0;
    logic       line        = 1'b1;
    int         cyc         = 0;
    logic [7:0] rx_q[$];
    int         start_cyc[$];
    int         done_cyc[$];

    int total = 0;
    int bad   = 0;

    assign tx_done = use_model ? done_model : done_manual;

    uart_tx_feeder #(.N_BITS(8), .ADDR_BITS(2)) dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_wr           (wr),
        .i_wdata        (wdata),
        .o_full         (full),
        .o_empty        (empty),
        .o_count        (count),
        .o_overflow     (overflow),
        .o_tx_start     (tx_start),
        .o_tx_data      (tx_data),
        .i_tx_done_tick (tx_done),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: frame = start bit, 8 data bits LSB first, stop bit; one bit per clock.
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        done_model <= 1'b0;
        if (done_model) begin
            rx_q.push_back(rx[8:1]);
            done_cyc.push_back(cyc);
        end
        if (use_model && !m_busy && tx_start) begin
            m_busy <= 1'b1;
            m_sh   <= {1'b1, tx_data, 1'b0};
            m_bit  <= '0;
            start_cyc.push_back(cyc);
        end else if (m_busy) begin
            line  <= m_sh[0];
            rx    <= {m_sh[0], rx[9:1]};
            m_sh  <= m_sh >> 1;
            m_bit <= m_bit + 4'd1;
            if (m_bit == 4'd9) begin
                m_busy     <= 1'b0;
                done_model <= 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wr    = 1'b0;
        wdata = 8'h00;

        // reset defaults
        repeat (3) tick();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_no_start", tx_start, 0);
        end

        // single byte: write in cycle 0, start pulse in cycle 2
        wr = 1'b1; wdata = 8'hA5;
        tick();
        wr = 1'b0;
        chk("single_c1_empty", empty, 0);
        chk("single_c1_start", tx_start, 0);
        tick();
        chk("single_c2_start", tx_start, 1);
        chk("single_c2_data", tx_data, 8'hA5);
        chk("single_c2_busy", busy, 1);
        tick();
        chk("single_c3_start", tx_start, 0);
        chk("single_c3_busy", busy, 1);
        tick(); tick();
        chk("single_wait_busy", busy, 1);
        done_manual = 1'b1;
        tick();
        done_manual = 1'b0;
        chk("single_done_busy", busy, 0);
        tick();
        chk("single_after_start", tx_start, 0);
        chk("single_data_held", tx_data, 8'hA5);

        // burst through the transmitter model; second write overlaps the first pop at count=1
        use_model = 1'b1;
        wr = 1'b1; wdata = 8'h11;
        tick();
        wdata = 8'h22;
        tick();
        chk("burst_pushpop_count", count, 1);
        chk("burst_first_start", tx_start, 1);
        chk("burst_first_data", tx_data, 8'h11);
        wdata = 8'h33;
        tick();
        wr = 1'b0;
        chk("burst_count2", count, 2);
        for (int i = 0; i < 200 && rx_q.size() < 3; i++) tick();
        chk("burst_rx_size", rx_q.size(), 3);
        if (rx_q.size() >= 3 && done_cyc.size() >= 2 && start_cyc.size() >= 3) begin
            chk("burst_rx0", rx_q[0], 8'h11);
            chk("burst_rx1", rx_q[1], 8'h22);
            chk("burst_rx2", rx_q[2], 8'h33);
            chk("burst_gap1", start_cyc[1] - done_cyc[0], 2);
            chk("burst_gap2", start_cyc[2] - done_cyc[1], 2);
        end
        tick(); tick();
        chk("burst_idle_busy", busy, 0);
        chk("burst_idle_empty", empty, 1);
        use_model = 1'b0;

        // overflow with done held low
        wr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wdata = 8'h61 + 8'(i);
            tick();
            if (i == 1) begin
                chk("ovf_first_start", tx_start, 1);
                chk("ovf_first_data", tx_data, 8'h61);
            end
            if (i == 4) begin
                chk("ovf_full", full, 1);
                chk("ovf_count4", count, 4);
                chk("ovf_not_yet", overflow, 0);
            end
        end
        wr = 1'b0;
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count_kept", count, 4);
        tick();
        chk("ovf_pulse_end", overflow, 0);
        chk("ovf_data_stable", tx_data, 8'h61);
        for (int j = 1; j <= 4; j++) begin
            tick();
            done_manual = 1'b1;
            tick();
            done_manual = 1'b0;
            tick();
            chk("drain_start", tx_start, 1);
            chk("drain_data", tx_data, 8'h61 + 8'(j));
        end
        tick();
        done_manual = 1'b1;
        tick();
        done_manual = 1'b0;
        tick();
        chk("drain_no_start", tx_start, 0);
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);
        chk("drain_busy", busy, 0);

        // spurious done in idle with empty FIFO
        done_manual = 1'b1;
        tick();
        done_manual = 1'b0;
        chk("spur_busy", busy, 0);
        chk("spur_start", tx_start, 0);
        tick();
        chk("spur_start2", tx_start, 0);

        // asynchronous reset mid-transfer
        wr = 1'b1; wdata = 8'h5A;
        tick();
        wdata = 8'h5B;
        tick();
        wr = 1'b0;
        tick();
        chk("mid_busy", busy, 1);
        chk("mid_count", count, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_empty", empty, 1);
        chk("async_count", count, 0);
        chk("async_busy", busy, 0);
        chk("async_data", tx_data, 0);
        chk("async_start", tx_start, 0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post_rst_start", tx_start, 0);
        chk("post_rst_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
